// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle initiator that reads two registers, drives the
// ALU, and writes back the result or updates sticky compare flags.
// Ports:
//   clk, reset                      clock, async active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_op/ctrl/dst/src             opcode, ALU control, dst/src registers
//   rf_raddr_a/b, rf_rdata_a/b      register-file read port
//   alu_op1/op2/op/ctrl             ALU inputs
//   alu_result/equal/less           ALU outputs
//   rf_we/waddr/wdata               register-file write port
//   flag_eq/flag_lt                 sticky compare flags
//   done, op_count                  completion pulse, completed-op counter
module alu_sequencer #(
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [1:0]    cmd_ctrl,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_src,
  output logic [AW-1:0] rf_raddr_a,
  output logic [AW-1:0] rf_raddr_b,
  input  logic [DW-1:0] rf_rdata_a,
  input  logic [DW-1:0] rf_rdata_b,
  output logic [DW-1:0] alu_op1,
  output logic [DW-1:0] alu_op2,
  output logic [2:0]    alu_op,
  output logic [1:0]    alu_ctrl,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_equal,
  input  logic          alu_less,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          flag_eq,
  output logic          flag_lt,
  output logic          done,
  output logic [CW-1:0] op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [1:0]    state;
  logic [2:0]    op_q;
  logic [1:0]    ctrl_q;
  logic [AW-1:0] dst_q;
  logic          is_cmp;

  // SLT, SLTE and EQ occupy the top three opcodes
  assign is_cmp    = (op_q == 3'b101) |
                     (op_q == 3'b110) |
                     (op_q == 3'b111);
  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= '0;
      ctrl_q     <= '0;
      dst_q      <= '0;
      rf_raddr_a <= '0;
      rf_raddr_b <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_op     <= '0;
      alu_ctrl   <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      flag_eq    <= 1'b0;
      flag_lt    <= 1'b0;
      done       <= 1'b0;
      op_count   <= '0;
    end else begin
      done  <= 1'b0;
      rf_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q       <= cmd_op;
            ctrl_q     <= cmd_ctrl;
            dst_q      <= cmd_dst;
            rf_raddr_a <= cmd_dst;
            rf_raddr_b <= cmd_src;
            state      <= READ;
          end
        end
        READ: begin
          alu_op1  <= rf_rdata_a;
          alu_op2  <= rf_rdata_b;
          alu_op   <= op_q;
          alu_ctrl <= ctrl_q;
          state    <= EXEC;
        end
        EXEC: begin
          rf_wdata <= alu_result;
          if (is_cmp) begin
            flag_eq <= alu_equal;
            flag_lt <= alu_less;
          end
          // done/rf_we are registered so they appear in the WB cycle
          done     <= 1'b1;
          rf_we    <= ~is_cmp;
          rf_waddr <= dst_q;
          op_count <= op_count + ONE;
          state    <= WB;
        end
        WB: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench with a register-file and ALU model
// around alu_sequencer, table vectors plus multi-cycle sequences.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [1:0] cmd_ctrl = '0;
  logic [2:0] cmd_dst = '0;
  logic [2:0] cmd_src = '0;
  logic [2:0] rf_raddr_a, rf_raddr_b;
  logic [7:0] rf_rdata_a, rf_rdata_b;
  logic [7:0] alu_op1, alu_op2;
  logic [2:0] alu_op;
  logic [1:0] alu_ctrl;
  logic [7:0] alu_result;
  logic       alu_equal, alu_less;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       flag_eq, flag_lt, done;
  logic [7:0] op_count;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ctrl(cmd_ctrl),
    .cmd_dst(cmd_dst), .cmd_src(cmd_src),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_op(alu_op), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_equal(alu_equal),
    .alu_less(alu_less),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flag_eq(flag_eq), .flag_lt(flag_lt),
    .done(done), .op_count(op_count)
  );

  logic [7:0] rf [8];
  logic       ld_en = 1'b0;
  logic [2:0] ld_addr = '0;
  logic [7:0] ld_data = '0;

  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  always @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    else if (ld_en) rf[ld_addr] <= ld_data;
  end

  always_comb begin
    alu_result = '0;
    alu_equal  = (alu_op1 == alu_op2);
    alu_less   = (alu_op1 < alu_op2);
    case (alu_op)
      3'd0: alu_result = alu_op1 & alu_op2;
      3'd1: alu_result = alu_op1 | alu_op2;
      3'd2: alu_result = alu_op1 ^ alu_op2;
      3'd3: alu_result = alu_op1 + alu_op2;
      3'd4: alu_result = alu_op1 - alu_op2;
      3'd5: begin
        alu_result = {7'd0, alu_op1 < alu_op2};
        alu_equal  = 1'b0;
      end
      3'd6: begin
        alu_result = {7'd0, alu_op1 <= alu_op2};
        alu_less   = (alu_op1 <= alu_op2);
      end
      default: begin
        alu_result = {7'd0, alu_op1 == alu_op2};
        alu_less   = 1'b0;
      end
    endcase
  end

  typedef struct {
    logic [2:0] op;
    logic [1:0] ctrl;
    logic [2:0] dst;
    logic [2:0] src;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] wdata;
    logic       we;
    logic       eq;
    logic       lt;
  } vec_t;

  vec_t vt [10];
  int   checks = 0;
  int   failures = 0;
  logic [7:0] exp_cnt = '0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run(input vec_t v);
    load(v.dst, v.a);
    load(v.src, v.b);
    @(negedge clk);
    chk("idle_ready", cmd_ready, 1);
    cmd_op = v.op; cmd_ctrl = v.ctrl;
    cmd_dst = v.dst; cmd_src = v.src;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("c1_ready", cmd_ready, 0);
    chk("c1_done", done, 0);
    @(posedge clk); #1;
    chk("c2_ready", cmd_ready, 0);
    chk("c2_op1", alu_op1, v.a);
    chk("c2_op2", alu_op2, v.b);
    chk("c2_aluop", alu_op, v.op);
    chk("c2_ctrl", alu_ctrl, v.ctrl);
    chk("c2_we", rf_we, 0);
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 8'd1;
    chk("wb_ready", cmd_ready, 0);
    chk("wb_done", done, 1);
    chk("wb_we", rf_we, v.we);
    if (v.we) chk("wb_waddr", rf_waddr, v.dst);
    chk("wb_wdata", rf_wdata, v.wdata);
    chk("wb_eq", flag_eq, v.eq);
    chk("wb_lt", flag_lt, v.lt);
    chk("wb_count", op_count, exp_cnt);
    @(posedge clk); #1;
    chk("c4_ready", cmd_ready, 1);
    chk("c4_done", done, 0);
    chk("c4_we", rf_we, 0);
    if (v.we) chk("rf_written", rf[v.dst], v.wdata);
  endtask

  initial begin
    int na, nd, bad;
    int acc [3];
    logic seen_we;

    vt[0] = '{3'd3, 2'd0, 3'd1, 3'd2, 8'h05, 8'h03, 8'h08, 1, 0, 0};
    vt[1] = '{3'd6, 2'd1, 3'd3, 3'd4, 8'h07, 8'h07, 8'h01, 0, 1, 1};
    vt[2] = '{3'd4, 2'd2, 3'd1, 3'd2, 8'h00, 8'h01, 8'hFF, 1, 1, 1};
    vt[3] = '{3'd5, 2'd3, 3'd3, 3'd4, 8'h07, 8'h07, 8'h00, 0, 0, 0};
    vt[4] = '{3'd0, 2'd1, 3'd5, 3'd6, 8'hF0, 8'h3C, 8'h30, 1, 0, 0};
    vt[5] = '{3'd1, 2'd2, 3'd5, 3'd6, 8'hA0, 8'h05, 8'hA5, 1, 0, 0};
    vt[6] = '{3'd7, 2'd0, 3'd2, 3'd7, 8'h42, 8'h42, 8'h01, 0, 1, 0};
    vt[7] = '{3'd2, 2'd3, 3'd0, 3'd1, 8'hFF, 8'h0F, 8'hF0, 1, 1, 0};
    vt[8] = '{3'd5, 2'd1, 3'd6, 3'd7, 8'h03, 8'h09, 8'h01, 0, 0, 1};
    vt[9] = '{3'd3, 2'd2, 3'd4, 3'd5, 8'hFF, 8'h02, 8'h01, 1, 0, 1};

    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_count", op_count, 0);
    chk("rst_flags", {flag_eq, flag_lt}, 0);
    chk("rst_op1", alu_op1, 0);
    chk("rst_raddr", rf_raddr_a, 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run(vt[i]);

    // reset while an ADD sits in EXEC
    load(3'd1, 8'h11);
    load(3'd2, 8'h22);
    @(negedge clk);
    cmd_op = 3'd3; cmd_dst = 3'd1; cmd_src = 3'd2;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_ready", cmd_ready, 1);
    chk("mid_flags", {flag_eq, flag_lt}, 0);
    chk("mid_count", op_count, 0);
    chk("mid_done", done, 0);
    chk("mid_we", rf_we, 0);
    bad = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || rf_we) bad++;
    end
    chk("mid_quiet", bad, 0);
    chk("mid_rf", rf[1], 8'h11);

    // valid held high: three XORs back to back
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    load(3'd1, 8'h0F);
    load(3'd2, 8'hFF);
    @(negedge clk);
    cmd_op = 3'd2; cmd_dst = 3'd1; cmd_src = 3'd2;
    cmd_valid = 1'b1;
    na = 0; nd = 0;
    for (int c = 0; c < 16; c++) begin
      if (na == 3) cmd_valid = 1'b0;
      if (done) nd++;
      if (cmd_valid && cmd_ready) begin
        if (na < 3) acc[na] = c;
        na++;
      end
      @(negedge clk);
    end
    chk("b2b_accepts", na, 3);
    chk("b2b_acc0", acc[0], 0);
    chk("b2b_acc1", acc[1], 4);
    chk("b2b_acc2", acc[2], 8);
    chk("b2b_dones", nd, 3);
    chk("b2b_count", op_count, 3);
    chk("b2b_rf", rf[1], 8'hF0);

    // 256 EQ commands wrap the counter
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    load(3'd2, 8'h11);
    load(3'd7, 8'h11);
    @(negedge clk);
    cmd_op = 3'd7; cmd_dst = 3'd2; cmd_src = 3'd7;
    cmd_valid = 1'b1;
    nd = 0; seen_we = 1'b0;
    for (int c = 0; c < 1100 && nd < 256; c++) begin
      @(negedge clk);
      if (rf_we) seen_we = 1'b1;
      if (done) begin
        nd++;
        if (nd == 255) chk("wrap_255", op_count, 8'hFF);
        if (nd == 256) begin
          cmd_valid = 1'b0;
          chk("wrap_0", op_count, 8'h00);
        end
      end
    end
    cmd_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rf_we) seen_we = 1'b1;
      if (done) nd++;
    end
    chk("wrap_dones", nd, 256);
    chk("wrap_no_we", seen_we, 0);
    chk("wrap_final", op_count, 8'h00);
    chk("wrap_flags", {flag_eq, flag_lt}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
